// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer
//   Sequences a tiled matrix product C = L x R through a systolic array:
//   waits for the HASH (A) source to hold a tile, optionally loads the
//   stationary weights from sp RAM (SA mode), streams K_LEN operand beats
//   into the array, waits out the array pipeline, then writes (or
//   accumulates) the TILE result rows into the result RAM.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode         job launch (mode 1 = AS, 2 = SA), ignored when busy
//   src_valid, src_ack  HASH tile handshake (ack pulses once per tile)
//   addr_a/en_a/data_a  HASH RAM read port (1-cycle latency)
//   addr_s/en_s/data_s  sp RAM read port (1-cycle latency)
//   data_left/right, arr_valid, arr_load_w, arr_clear, res_row, res_data
//                       systolic array interface
//   addr_b_rd/data_b_rd result RAM read port (1-cycle latency)
//   addr_b_wr/data_b_wr/wen_b  result RAM write port
//   busy, done, state_o, err_mode  status
module mm_tile_sequencer #(
  parameter int DATA_W   = 64,
  parameter int LANE_W   = 16,
  parameter int ADDR_W   = 32,
  parameter int TILE     = 4,
  parameter int K_LEN    = 1344,
  parameter int ROWS_T   = 336,
  parameter int COLS_T   = 2,
  parameter int PIPE_LAT = 8,
  parameter int A_BASE   = 0,
  parameter int S_BASE   = 0,
  parameter int B_BASE   = 86016,
  parameter int ACCUM    = 1,
  localparam int RW      = (TILE > 1) ? $clog2(TILE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              src_valid,
  output logic              src_ack,
  output logic [ADDR_W-1:0] addr_a,
  output logic              en_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [ADDR_W-1:0] addr_s,
  output logic              en_s,
  input  logic [DATA_W-1:0] data_s,
  output logic [DATA_W-1:0] data_left,
  output logic [DATA_W-1:0] data_right,
  output logic              arr_valid,
  output logic              arr_load_w,
  output logic              arr_clear,
  output logic [RW-1:0]     res_row,
  input  logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] addr_b_rd,
  output logic [ADDR_W-1:0] addr_b_wr,
  input  logic [DATA_W-1:0] data_b_rd,
  output logic [DATA_W-1:0] data_b_wr,
  output logic              wen_b,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_o,
  output logic              err_mode
);

  localparam int LANES   = DATA_W / LANE_W;
  localparam int CNT_MAX = (K_LEN > PIPE_LAT + 1) ?
                           ((K_LEN > TILE + 1) ? K_LEN : TILE + 1) :
                           ((PIPE_LAT + 1 > TILE + 1) ? PIPE_LAT + 1 : TILE + 1);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TRW     = (ROWS_T > 1) ? $clog2(ROWS_T) : 1;
  localparam int TCW     = (COLS_T > 1) ? $clog2(COLS_T) : 1;

  localparam logic [ADDR_W-1:0] A_BASE_A = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] S_BASE_A = ADDR_W'(S_BASE);
  localparam logic [ADDR_W-1:0] B_BASE_A = ADDR_W'(B_BASE);
  localparam logic [ADDR_W-1:0] K_LEN_A  = ADDR_W'(K_LEN);
  localparam logic [ADDR_W-1:0] TILE_A   = ADDR_W'(TILE);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS_T);

  localparam logic [1:0] MODE_AS = 2'd1;
  localparam logic [1:0] MODE_SA = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SRC = 3'd1,
    LOAD_W   = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4,
    SAVE     = 3'd5,
    FIN      = 3'd6
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [TRW-1:0]     tr_reg, tr_next;
  logic [TCW-1:0]     tc_reg, tc_next;
  logic [1:0]         mode_reg, mode_next;

  // Flags describing what was issued to the RAMs last cycle; the read
  // data returning this cycle is qualified by them.
  logic               valid_reg, load_reg, stream_reg;
  // Pending result write: address and array row captured on the read cycle.
  logic               wr_pend_reg;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic [DATA_W-1:0]  res_reg;

  logic [ADDR_W-1:0]  tr_a, tc_a, cnt_a;
  logic               save_rd;

  assign tr_a    = ADDR_W'(tr_reg);
  assign tc_a    = ADDR_W'(tc_reg);
  assign cnt_a   = ADDR_W'(cnt_reg);
  assign save_rd = (state_reg == SAVE) && (cnt_reg < CW'(TILE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      tr_reg      <= '0;
      tc_reg      <= '0;
      mode_reg    <= '0;
      valid_reg   <= 1'b0;
      load_reg    <= 1'b0;
      stream_reg  <= 1'b0;
      wr_pend_reg <= 1'b0;
      wr_addr_reg <= '0;
      res_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      tr_reg      <= tr_next;
      tc_reg      <= tc_next;
      mode_reg    <= mode_next;
      valid_reg   <= (state_reg == LOAD_W) || (state_reg == STREAM);
      load_reg    <= (state_reg == LOAD_W);
      stream_reg  <= (state_reg == STREAM);
      wr_pend_reg <= save_rd;
      wr_addr_reg <= save_rd ? addr_b_rd : '0;
      res_reg     <= save_rd ? res_data : '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tr_next    = tr_reg;
    tc_next    = tc_reg;
    mode_next  = mode_reg;
    en_a       = 1'b0;
    addr_a     = '0;
    en_s       = 1'b0;
    addr_s     = '0;
    arr_clear  = 1'b0;
    res_row    = '0;
    addr_b_rd  = '0;
    src_ack    = 1'b0;
    err_mode   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (mode == MODE_AS || mode == MODE_SA) begin
            mode_next  = mode;
            tr_next    = '0;
            tc_next    = '0;
            cnt_next   = '0;
            state_next = WAIT_SRC;
          end else begin
            err_mode = 1'b1;
          end
        end
      end

      WAIT_SRC: begin
        if (src_valid) begin
          arr_clear  = 1'b1;
          cnt_next   = '0;
          state_next = (mode_reg == MODE_SA) ? LOAD_W : STREAM;
        end
      end

      LOAD_W: begin
        en_s   = 1'b1;
        addr_s = S_BASE_A + tc_a * TILE_A + cnt_a;
        if (cnt_reg == CW'(TILE - 1)) begin
          cnt_next   = '0;
          state_next = STREAM;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STREAM: begin
        en_a   = 1'b1;
        addr_a = A_BASE_A + tr_a * K_LEN_A + cnt_a;
        if (mode_reg == MODE_AS) begin
          en_s   = 1'b1;
          addr_s = S_BASE_A + tc_a * K_LEN_A + cnt_a;
        end
        if (cnt_reg == CW'(K_LEN - 1)) begin
          cnt_next   = '0;
          state_next = DRAIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DRAIN: begin
        if (cnt_reg == CW'(PIPE_LAT)) begin
          cnt_next   = '0;
          state_next = SAVE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      SAVE: begin
        if (save_rd) begin
          res_row   = cnt_reg[RW-1:0];
          addr_b_rd = B_BASE_A + (tr_a * COLS_A + tc_a) * TILE_A + cnt_a;
        end
        if (cnt_reg == CW'(TILE)) begin
          // Last SAVE cycle: the final write is on the bus, release the tile.
          src_ack  = 1'b1;
          cnt_next = '0;
          if (tc_reg == TCW'(COLS_T - 1)) begin
            tc_next = '0;
            if (tr_reg == TRW'(ROWS_T - 1)) begin
              tr_next    = '0;
              state_next = FIN;
            end else begin
              tr_next    = tr_reg + 1'b1;
              state_next = WAIT_SRC;
            end
          end else begin
            tc_next    = tc_reg + 1'b1;
            state_next = WAIT_SRC;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read data is forwarded only in the cycle after the matching issue, so
  // the array buses are zero whenever nothing meaningful is returning.
  assign arr_valid  = valid_reg;
  assign arr_load_w = load_reg;
  assign data_left  = stream_reg ? data_a : '0;
  assign data_right = (load_reg || (stream_reg && mode_reg == MODE_AS)) ? data_s : '0;

  assign wen_b     = wr_pend_reg;
  assign addr_b_wr = wr_pend_reg ? wr_addr_reg : '0;

  // Lane-wise add: each lane wraps on its own, no carry crosses lanes.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] old_lane;
    logic [LANE_W-1:0] sum_lane;
    assign old_lane = (ACCUM != 0) ? data_b_rd[gi*LANE_W +: LANE_W] : '0;
    assign sum_lane = old_lane + res_reg[gi*LANE_W +: LANE_W];
    assign data_b_wr[gi*LANE_W +: LANE_W] = wr_pend_reg ? sum_lane : '0;
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == FIN);
  assign state_o = state_reg;

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// tb_mm_tile_sequencer
//   Scoreboard bench for mm_tile_sequencer with small tiling parameters.
//   Expected RAM addresses, array data and result writes are queued when a
//   job is launched and popped as the DUT produces them.
module tb_mm_tile_sequencer;
  localparam int DW       = 64;
  localparam int AW       = 32;
  localparam int TILE     = 4;
  localparam int K_LEN    = 8;
  localparam int ROWS_T   = 2;
  localparam int COLS_T   = 1;
  localparam int PIPE_LAT = 3;
  localparam int B_BASE   = 64;
  localparam logic [63:0] PRELOAD = 64'hFFFF_0001_0002_0003;

  logic          clk, rst_n, start, src_valid, src_ack;
  logic [1:0]    mode;
  logic [AW-1:0] addr_a, addr_s, addr_b_rd, addr_b_wr;
  logic          en_a, en_s, arr_valid, arr_load_w, arr_clear, wen_b;
  logic [DW-1:0] data_a, data_s, data_left, data_right, res_data;
  logic [DW-1:0] data_b_rd, data_b_wr;
  logic [1:0]    res_row;
  logic          busy, done, err_mode;
  logic [2:0]    state_o;
  logic          preload_req;
  logic [15:0]   res_lane;
  logic [63:0]   res_mem [256];

  mm_tile_sequencer #(
    .DATA_W(DW), .LANE_W(16), .ADDR_W(AW), .TILE(TILE), .K_LEN(K_LEN),
    .ROWS_T(ROWS_T), .COLS_T(COLS_T), .PIPE_LAT(PIPE_LAT), .A_BASE(0),
    .S_BASE(0), .B_BASE(B_BASE), .ACCUM(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_valid(src_valid), .src_ack(src_ack),
    .addr_a(addr_a), .en_a(en_a), .data_a(data_a),
    .addr_s(addr_s), .en_s(en_s), .data_s(data_s),
    .data_left(data_left), .data_right(data_right),
    .arr_valid(arr_valid), .arr_load_w(arr_load_w), .arr_clear(arr_clear),
    .res_row(res_row), .res_data(res_data),
    .addr_b_rd(addr_b_rd), .addr_b_wr(addr_b_wr),
    .data_b_rd(data_b_rd), .data_b_wr(data_b_wr), .wen_b(wen_b),
    .busy(busy), .done(done), .state_o(state_o), .err_mode(err_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] a_word(input logic [31:0] i);
    return 64'hA5A5_0000_0000_0000 | {32'd0, i};
  endfunction

  function automatic logic [63:0] s_word(input logic [31:0] i);
    return 64'h5A5A_0000_0000_0000 | {32'd0, i};
  endfunction

  function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
    return r;
  endfunction

  // Array result for row r: every lane holds r+1.
  assign res_lane = {14'd0, res_row} + 16'd1;
  assign res_data = {4{res_lane}};

  // RAM models, 1-cycle read latency.
  always @(posedge clk) begin
    data_a    <= a_word(addr_a);
    data_s    <= s_word(addr_s);
    data_b_rd <= res_mem[addr_b_rd[7:0]];
    if (preload_req) begin
      for (int i = 0; i < 256; i++) res_mem[i] <= PRELOAD;
    end else if (wen_b) begin
      res_mem[addr_b_wr[7:0]] <= data_b_wr;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] q_a[$], q_s[$], q_w[$], q_l[$], q_r[$], q_wa[$], q_wd[$];

  task automatic clear_queues();
    q_a.delete(); q_s.delete(); q_w.delete(); q_l.delete();
    q_r.delete(); q_wa.delete(); q_wd.delete();
  endtask

  task automatic push_expect(input logic [1:0] m);
    logic [31:0] ad;
    for (int tr = 0; tr < ROWS_T; tr++) begin
      for (int tc = 0; tc < COLS_T; tc++) begin
        if (m == 2'd2) begin
          for (int r = 0; r < TILE; r++) begin
            ad = 32'(tc * TILE + r);
            q_s.push_back(64'(ad));
            q_w.push_back(s_word(ad));
          end
        end
        for (int j = 0; j < K_LEN; j++) begin
          ad = 32'(tr * K_LEN + j);
          q_a.push_back(64'(ad));
          q_l.push_back(a_word(ad));
          if (m == 2'd1) begin
            ad = 32'(tc * K_LEN + j);
            q_s.push_back(64'(ad));
            q_r.push_back(s_word(ad));
          end else begin
            q_r.push_back(64'd0);
          end
        end
        for (int i = 0; i < TILE; i++) begin
          q_wa.push_back(64'(B_BASE + (tr * COLS_T + tc) * TILE + i));
          q_wd.push_back(lane_add(PRELOAD, {4{16'(i + 1)}}));
        end
      end
    end
  endtask

  task automatic run_seq(input logic [1:0] m, input bit stall, input bit abort);
    int busy_cnt = 0, done_cnt = 0, clr_cnt = 0, err_cnt = 0, ack_cnt = 0;
    int stall_left = 0, save_idx = 0, exp_busy;
    bit finished = 0, aborted = 0;
    clear_queues();
    push_expect(m);
    @(posedge clk); #1;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    start = 1'b1;
    mode = m;
    src_valid = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      clr_cnt  += int'(arr_clear);
      err_cnt  += int'(err_mode);
      if (en_a) begin
        if (q_a.size() == 0) check_eq("extra_en_a", 1, 0);
        else check_eq("addr_a", 64'(addr_a), q_a.pop_front());
      end
      if (en_s) begin
        if (q_s.size() == 0) check_eq("extra_en_s", 1, 0);
        else check_eq("addr_s", 64'(addr_s), q_s.pop_front());
      end
      if (arr_valid) begin
        if (arr_load_w) begin
          if (q_w.size() == 0) check_eq("extra_load_w", 1, 0);
          else check_eq("weight_data", data_right, q_w.pop_front());
        end else begin
          if (q_l.size() == 0) check_eq("extra_stream", 1, 0);
          else begin
            check_eq("data_left", data_left, q_l.pop_front());
            check_eq("data_right", data_right, q_r.pop_front());
          end
        end
      end
      if (wen_b) begin
        $display("wr addr=%0d data=%h", addr_b_wr, data_b_wr);
        if (q_wa.size() == 0) check_eq("extra_wen_b", 1, 0);
        else begin
          check_eq("addr_b_wr", 64'(addr_b_wr), q_wa.pop_front());
          check_eq("data_b_wr", data_b_wr, q_wd.pop_front());
        end
      end
      if (!src_valid) begin
        check_eq("stall_state", 64'(state_o), 64'd1);
        check_eq("stall_en_a", 64'(en_a), 64'd0);
        check_eq("stall_clear", 64'(arr_clear), 64'd0);
        stall_left--;
      end
      if (src_ack) begin
        ack_cnt++;
        if (stall && ack_cnt == 1) stall_left = 10;
      end
      if (state_o == 3'd5) begin
        if (abort && save_idx == 2) begin
          rst_n = 1'b0;
          aborted = 1;
          break;
        end
        save_idx++;
      end else begin
        save_idx = 0;
      end
      if (done) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      start = (cyc == 5);   // a second start while busy must be ignored
      src_valid = (stall_left == 0);
    end
    start = 1'b0;
    src_valid = 1'b1;
    if (aborted) begin
      #1;
      check_eq("rst_state", 64'(state_o), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_wen_b", 64'(wen_b), 64'd0);
      check_eq("rst_ctrl", 64'({arr_valid, arr_load_w, en_a, en_s, done, src_ack}), 64'd0);
      check_eq("rst_buses", 64'(|{addr_a, addr_s, addr_b_rd, addr_b_wr,
                                  data_b_wr, data_left, data_right}), 64'd0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_eq("rst_hold_wen_b", 64'(wen_b), 64'd0);
      end
      rst_n = 1'b1;
      clear_queues();
    end else begin
      check_eq("finished", 64'(finished), 64'd1);
      @(negedge clk);
      check_eq("busy_after", 64'(busy), 64'd0);
      check_eq("done_after", 64'(done), 64'd0);
      exp_busy = ROWS_T * COLS_T * (1 + K_LEN + (PIPE_LAT + 1) + (TILE + 1)) + 1
                 + ((m == 2'd2) ? ROWS_T * COLS_T * TILE : 0) + (stall ? 10 : 0);
      check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
      check_eq("done_pulses", 64'(done_cnt), 64'd1);
      check_eq("clear_pulses", 64'(clr_cnt), 64'(ROWS_T * COLS_T));
      check_eq("ack_pulses", 64'(ack_cnt), 64'(ROWS_T * COLS_T));
      check_eq("err_pulses", 64'(err_cnt), 64'd0);
      check_eq("left_a", 64'(q_a.size() + q_l.size()), 64'd0);
      check_eq("left_s", 64'(q_s.size() + q_w.size()), 64'd0);
      check_eq("left_wr", 64'(q_wa.size()), 64'd0);
    end
  endtask

  task automatic bad_mode(input logic [1:0] m);
    @(posedge clk); #1;
    start = 1'b1;
    mode = m;
    @(negedge clk);
    check_eq("err_mode_pulse", 64'(err_mode), 64'd1);
    check_eq("err_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("err_mode_clear", 64'(err_mode), 64'd0);
    check_eq("err_state", 64'(state_o), 64'd0);
    check_eq("err_busy2", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    src_valid = 1'b1;
    preload_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_state", 64'(state_o), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_outs", 64'({en_a, en_s, wen_b, arr_valid, done, src_ack}), 64'd0);
    rst_n = 1'b1;
    run_seq(2'd1, 1'b0, 1'b0);   // AS
    run_seq(2'd2, 1'b0, 1'b0);   // SA
    run_seq(2'd1, 1'b1, 1'b0);   // AS with a 10-cycle source stall
    bad_mode(2'd3);
    bad_mode(2'd0);
    run_seq(2'd1, 1'b0, 1'b1);   // reset during SAVE cycle 2
    run_seq(2'd1, 1'b0, 1'b0);   // full run after the abort
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mm_tile_sequencer.md
Name: mm_tile_sequencer

Overview:
Parametrised successor to the AS/SA memory controller. It sequences operand fetch, systolic-array feed, pipeline drain and result write-back for a tiled matrix product C = L×R. Tile count, tile size, inner length and base addresses are all parameters. It adds a ready/valid handshake to the hash (A) source, optional read-modify-write accumulation into the result RAM, and a done/busy interface. It sits between the BRAMs (sp, HASH, result) and the systolic array with its ping-pong transposers.

Parameters:
DATA_W, 64, bus width of every RAM word.
LANE_W, 16, element width; DATA_W/LANE_W lanes per word.
ADDR_W, 32, address width.
TILE, 4, array dimension; beats per weight load and per save.
K_LEN, 1344, inner dimension in words; must be a multiple of TILE.
ROWS_T, 336, row tiles.
COLS_T, 2, column tiles.
PIPE_LAT, 8, cycles from last stream beat to valid array result.
A_BASE, 0, HASH RAM base.
S_BASE, 0, sp RAM base.
B_BASE, 86016, result RAM base.
ACCUM, 1, 1 = read-modify-write accumulation, 0 = overwrite.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; ignored unless idle
mode  in  2  1 = AS (both operands streamed), 2 = SA (S stationary, A streamed); 0/3 rejected
src_valid  in  1  HASH RAM holds the next tile's A data
src_ack  out  1  one-cycle pulse: tile consumed
addr_a  out  ADDR_W  HASH read address
en_a  out  1  HASH read enable
data_a  in  DATA_W  HASH read data (1-cycle latency)
addr_s  out  ADDR_W  sp read address
en_s  out  1  sp read enable
data_s  in  DATA_W  sp read data (1-cycle latency)
data_left  out  DATA_W  array left input
data_right  out  DATA_W  array right input
arr_valid  out  1  left/right data valid this cycle
arr_load_w  out  1  data_right is a stationary-weight word
arr_clear  out  1  one-cycle pulse: clear accumulators/transposers
res_row  out  log2(TILE)  result row select
res_data  in  DATA_W  array result for res_row (combinational)
addr_b_rd  out  ADDR_W  result RAM read address
addr_b_wr  out  ADDR_W  result RAM write address
data_b_rd  in  DATA_W  result RAM read data (1-cycle latency)
data_b_wr  out  DATA_W  result RAM write data
wen_b  out  1  result RAM write enable
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final write
state_o  out  3  current state code
err_mode  out  1  one-cycle pulse: start rejected because of illegal mode

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0.
- State codes: IDLE = 0, WAIT_SRC = 1, LOAD_W = 2, STREAM = 3, DRAIN = 4, SAVE = 5, FIN = 6.
- IDLE:
  - start with legal mode: latch mode, clear tr/tc, go to WAIT_SRC, assert busy.
  - start with illegal mode: pulse err_mode, stay in IDLE.
- WAIT_SRC:
  - Hold until src_valid = 1.
  - On leaving, pulse arr_clear (the same cycle as the transition).
  - Next state is LOAD_W if mode = SA, else STREAM.
- LOAD_W (SA only):
  - TILE cycles, beat r = 0..TILE-1.
  - en_s = 1, addr_s = S_BASE + tc·TILE + r.
  - One cycle later: data_right = data_s, arr_load_w = 1, arr_valid = 1.
- STREAM:
  - K_LEN cycles, beat j = 0..K_LEN-1.
  - en_a = 1, addr_a = A_BASE + tr·K_LEN + j.
  - In AS mode also: en_s = 1, addr_s = S_BASE + tc·K_LEN + j.
  - One cycle later: data_left = data_a, data_right = data_s (AS) or 0 (SA), arr_valid = 1.
  - The last LOAD_W beat flows into the first STREAM issue with no bubble.
- DRAIN:
  - PIPE_LAT+1 cycles, absorbing the read latency plus the array pipeline.
  - arr_valid falls one cycle after the last issue.
- SAVE:
  - TILE+1 cycles. Cycle i < TILE: res_row = i, addr_b_rd = B_BASE + (tr·COLS_T + tc)·TILE + i.
  - Cycle i+1: wen_b = 1, addr_b_wr = the previous addr_b_rd.
  - Write data, ACCUM = 1: lane-wise data_b_wr = data_b_rd + registered res_data, mod 2^LANE_W, no carry between lanes.
  - Write data, ACCUM = 0: data_b_wr = registered res_data.
  - Writes are therefore issued on SAVE cycles 1..TILE.
- After SAVE, advance the tile counters:
  - Pulse src_ack.
  - tc increments; when tc wraps COLS_T-1 → 0, tr increments.
  - If tr wrapped ROWS_T-1 → 0, go to FIN; otherwise go to WAIT_SRC.
- FIN: pulse done, drop busy, go to IDLE.
- Boundaries and invariants:
  - start while busy is ignored.
  - src_valid is sampled only in WAIT_SRC.
  - Address arithmetic is ADDR_W unsigned and wraps silently.
  - rst_n low mid-operation aborts immediately: no further wen_b, counters cleared.
  - Outputs not listed as active in a state are 0 (address buses are 0 when their enable is low).

Test Plan:
- TILE=4, K_LEN=8, ROWS_T=2, COLS_T=1, PIPE_LAT=3, mode=AS, src_valid tied 1:
  - addr_a sequence 0..7 and then 8..15; addr_s sequence 0..7 twice.
  - wen_b fires 8 times at addresses B_BASE+0..7.
  - Exactly one done pulse; busy is high for 2·(1+8+4+5)+1 = 37 cycles.
- Same parameters, mode=SA:
  - 4 arr_load_w beats (addr_s 0..3) precede each 8-beat stream.
  - data_right = 0 during the stream.
- ACCUM=1 with result RAM preloaded to 0xFFFF_0001_0002_0003 and res_data = 0x0001_0001_0001_0001:
  - Written word is 0x0000_0002_0003_0004 (lane wrap, no carry into the next lane).
- src_valid held low for 10 cycles before the second tile:
  - state_o stays 1 and no en_a for those cycles.
  - arr_clear pulses exactly once when src_valid rises.
- start with mode=3:
  - err_mode pulses once, busy stays 0.
- rst_n asserted during SAVE cycle 2:
  - All outputs are 0 next cycle; no further wen_b.
  - A subsequent start runs a full, correct sequence.
